// File: rtl/main_mem_responder.sv
// Main-memory responder for the data cache: serves block fetches and
// write-through word writes, each completing after a fixed latency with a
// one-cycle Ready pulse.
module main_mem_responder #(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned RD_LATENCY      = 4,
    parameter int unsigned WR_LATENCY      = 2
) (
    input  logic                              CLK,
    input  logic                              rst,
    input  logic                              EnMain_Rd,
    input  logic                              Mem_Wr,
    input  logic [ADDR_W-1:0]                 Addr,
    input  logic [DATA_W-1:0]                 Wr_Data,
    output logic                              Ready,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] Block_Data,
    output logic                              Busy
);

    localparam int unsigned OffW   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CntW   = ($clog2(MaxLat) > 0) ? $clog2(MaxLat) : 1;
    localparam int unsigned Depth  = 1 << ADDR_W;
    localparam int unsigned BlkW   = DATA_W * WORDS_PER_BLOCK;

    localparam logic [CntW-1:0] RdLoad = CntW'(RD_LATENCY - 1);
    localparam logic [CntW-1:0] WrLoad = CntW'(WR_LATENCY - 1);

    // Reject illegal configurations at elaboration.
    if (RD_LATENCY < 1 || WR_LATENCY < 1) begin : gen_bad_latency
        $error("main_mem_responder: latencies must be at least 1");
    end
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : gen_bad_wpb
        $error("main_mem_responder: WORDS_PER_BLOCK must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic [BlkW-1:0]   block_q, block_d;
    logic [BlkW-1:0]   rd_block;
    logic              commit_wr;

    logic [DATA_W-1:0] mem [Depth];

    // Gather the block at the latched (already aligned) base address.
    always_comb begin
        rd_block = '0;
        for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) begin
            rd_block[i*DATA_W +: DATA_W] = mem[{addr_q[ADDR_W-1:OffW], OffW'(i)}];
        end
    end

    // Write lands on the same edge that raises Ready.
    assign commit_wr = (state_q == StWrWait) && (cnt_q == '0);

    // Next-state, counter, latches and completion logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        block_d = block_q;
        unique case (state_q)
            StIdle: begin
                // Write wins over read, mirroring the cache controller.
                if (Mem_Wr) begin
                    state_d = StWrWait;
                    cnt_d   = WrLoad;
                    addr_d  = Addr;
                    wdata_d = Wr_Data;
                end else if (EnMain_Rd) begin
                    state_d = StRdWait;
                    cnt_d   = RdLoad;
                    addr_d  = {Addr[ADDR_W-1:OffW], OffW'(0)};
                end
            end
            StRdWait, StWrWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    ready_d = 1'b1;
                    state_d = StIdle;
                    if (state_q == StRdWait) begin
                        block_d = rd_block;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and data registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            block_q <= block_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge CLK) begin
        if (commit_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign Ready      = ready_q;
    assign Block_Data = block_q;
    assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: default-latency instance plus a
// latency-1 instance, with a scoreboard of expected completions.
module tb_main_mem_responder;

    logic         CLK;
    logic         rst;
    logic         rd0, wr0, rd1, wr1;
    logic [9:0]   Addr;
    logic [31:0]  Wr_Data;
    logic         ready0, busy0, ready1, busy1;
    logic [127:0] blk0, blk1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_rd;
        logic [127:0] blk;
        logic [127:0] mask;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  mdl   [2][1024];
    bit           known [2][1024];
    logic [127:0] last_blk  [2];
    logic [127:0] last_mask [2];

    main_mem_responder dut (
        .CLK       (CLK),
        .rst       (rst),
        .EnMain_Rd (rd0),
        .Mem_Wr    (wr0),
        .Addr      (Addr),
        .Wr_Data   (Wr_Data),
        .Ready     (ready0),
        .Block_Data(blk0),
        .Busy      (busy0)
    );

    main_mem_responder #(
        .RD_LATENCY(1),
        .WR_LATENCY(1)
    ) dut1 (
        .CLK       (CLK),
        .rst       (rst),
        .EnMain_Rd (rd1),
        .Mem_Wr    (wr1),
        .Addr      (Addr),
        .Wr_Data   (Wr_Data),
        .Ready     (ready1),
        .Block_Data(blk1),
        .Busy      (busy1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic rdy(input int sel);
        return (sel != 0) ? ready1 : ready0;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic [127:0] blk(input int sel);
        return (sel != 0) ? blk1 : blk0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drop all requests and confirm both instances are quiet one cycle later.
    task automatic release_reqs();
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        @(posedge CLK); #1;
        chk("ready_low_0", 128'(ready0), 128'(0));
        chk("ready_low_1", 128'(ready1), 128'(0));
        chk("idle_busy_0", 128'(busy0), 128'(0));
        chk("idle_busy_1", 128'(busy1), 128'(0));
    endtask

    // Issue one request and follow it to its Ready pulse. Requests are left
    // asserted afterwards so a following call captures on the falling-Ready edge.
    task automatic req(input int sel, input bit is_wr, input bit also_rd,
                       input logic [9:0] a, input logic [31:0] d,
                       input int lat, input bit mid_change);
        exp_t       e;
        logic [9:0] base;
        int         seen;
        int         busy_cnt;
        Addr    = a;
        Wr_Data = d;
        if (is_wr) begin
            e.is_rd = 1'b0;
            e.blk   = last_blk[sel];
            e.mask  = last_mask[sel];
        end else begin
            e.is_rd = 1'b1;
            e.blk   = '0;
            e.mask  = '0;
            base    = {a[9:2], 2'b00};
            for (int i = 0; i < 4; i++) begin
                if (known[sel][int'(base) + i]) begin
                    e.blk[i*32 +: 32]  = mdl[sel][int'(base) + i];
                    e.mask[i*32 +: 32] = '1;
                end
            end
        end
        sb.push_back(e);
        if (sel == 0) begin
            wr0 = is_wr; rd0 = !is_wr || also_rd;
        end else begin
            wr1 = is_wr; rd1 = !is_wr || also_rd;
        end
        @(posedge CLK); #1;
        chk("ready_at_capture", 128'(rdy(sel)), 128'(0));
        seen     = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (mid_change && k == 2) begin
                Addr = 10'h3F0;
                rd0  = 1'b0;
            end
            if (bsy(sel)) busy_cnt++;
            @(posedge CLK); #1;
            if (rdy(sel)) begin
                seen = k;
                break;
            end
        end
        chk("latency", 128'(seen), 128'(lat));
        chk("busy_cycles", 128'(busy_cnt), 128'(lat));
        chk("busy_at_ready", 128'(bsy(sel)), 128'(0));
        e = sb.pop_front();
        chk(e.is_rd ? "rd_block" : "blk_hold_on_wr", blk(sel) & e.mask, e.blk & e.mask);
        if (e.is_rd) begin
            last_blk[sel]  = e.blk;
            last_mask[sel] = e.mask;
        end else if (seen != 0) begin
            mdl[sel][int'(a)]   = d;
            known[sel][int'(a)] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        Addr = '0; Wr_Data = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) begin
                known[s][i] = 1'b0;
                mdl[s][i]   = '0;
            end
            last_blk[s]  = '0;
            last_mask[s] = '1;
        end

        // Reset state.
        #1;
        chk("rst_ready", 128'(ready0), 128'(0));
        chk("rst_busy", 128'(busy0), 128'(0));
        chk("rst_block", blk0, 128'(0));
        chk("rst_block_1", blk1, 128'(0));
        @(posedge CLK); @(posedge CLK); #1;
        rst = 1'b0;
        @(posedge CLK); #1;

        // Write then read back through the containing block.
        req(0, 1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 2, 1'b0);
        release_reqs();
        req(0, 1'b0, 1'b0, 10'h006, 32'h0, 4, 1'b0);
        release_reqs();

        // Back-to-back writes with Mem_Wr held high, then read them back.
        req(0, 1'b1, 1'b0, 10'h010, 32'h11111111, 2, 1'b0);
        req(0, 1'b1, 1'b0, 10'h011, 32'h22222222, 2, 1'b0);
        req(0, 1'b1, 1'b0, 10'h012, 32'h33333333, 2, 1'b0);
        release_reqs();
        req(0, 1'b0, 1'b0, 10'h012, 32'h0, 4, 1'b0);
        release_reqs();

        // Simultaneous read and write: only the write happens.
        req(0, 1'b1, 1'b1, 10'h011, 32'h55AA55AA, 2, 1'b0);
        release_reqs();

        // Inputs change mid-wait; block still comes from the captured address.
        req(0, 1'b0, 1'b0, 10'h013, 32'h0, 4, 1'b1);
        release_reqs();

        // Reset during a write discards it.
        req(0, 1'b1, 1'b0, 10'h020, 32'hAAAAAAAA, 2, 1'b0);
        release_reqs();
        Addr = 10'h020; Wr_Data = 32'h12345678; wr0 = 1'b1;
        @(posedge CLK); #1;
        chk("rw_busy_capture", 128'(busy0), 128'(1));
        @(posedge CLK); #1;
        #2 rst = 1'b1;
        #1;
        chk("rw_busy_async", 128'(busy0), 128'(0));
        chk("rw_ready_async", 128'(ready0), 128'(0));
        chk("rw_block_clr", blk0, 128'(0));
        wr0 = 1'b0;
        @(posedge CLK); #1;
        chk("rw_ready_held", 128'(ready0), 128'(0));
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_blk[s]  = '0;
            last_mask[s] = '1;
        end
        @(posedge CLK); #1;
        req(0, 1'b0, 1'b0, 10'h021, 32'h0, 4, 1'b0);
        release_reqs();

        // Latency-1 instance.
        req(1, 1'b1, 1'b0, 10'h100, 32'hCAFEF00D, 1, 1'b0);
        req(1, 1'b1, 1'b0, 10'h101, 32'h0BADC0DE, 1, 1'b0);
        release_reqs();
        req(1, 1'b0, 1'b0, 10'h102, 32'h0, 1, 1'b0);
        release_reqs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
